// File: rtl/ternary_stream_tx.sv
// Session transmitter for the tiny-ternary core: buffers one weight set, then streams header, weights and bit-plane frames.
// Define TERNARY_TX_WEIGHT_REUSE_EN to add start_reuse, which replays the held weight set without refilling.
//   state  | meaning
//   S_DRST | core held in reset for 2 cycles
//   S_IDLE | waiting for start, bus idle
//   S_FILL | accepting the weight set into the buffer
//   S_HDR  | header word {bsel, 4'h1}
//   S_LOAD | weight burst replayed from the buffer
//   S_MULT | bit-serial activation frames, LSB plane first
module ternary_stream_tx #(
    parameter int MAX_IN_LEN   = 12,
    parameter int MAX_OUT_LEN  = 12,
    parameter int WEIGHT_WIDTH = 2,
    parameter int ACT_WIDTH    = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic                            stop,
`ifdef TERNARY_TX_WEIGHT_REUSE_EN
    input  logic                            start_reuse,
`endif
    input  logic [7:0]                      cfg_bit_select,
    input  logic [MAX_IN_LEN-1:0]           w_data,
    input  logic                            w_valid,
    output logic                            w_ready,
    input  logic [MAX_IN_LEN*ACT_WIDTH-1:0] a_data,
    input  logic                            a_valid,
    output logic                            a_ready,
    output logic [MAX_IN_LEN-1:0]           tx_word,
    output logic                            dut_rst_n,
    output logic                            frame_start,
    output logic                            frame_valid,
    output logic                            busy
);

    localparam int NW = WEIGHT_WIDTH * MAX_OUT_LEN;
    localparam int CW = 5;
    localparam int PW = $clog2(ACT_WIDTH);
    localparam int VW = MAX_IN_LEN * ACT_WIDTH;
    localparam logic [CW-1:0] LAST_IDX = CW'(NW - 1);
    localparam logic [7:0]    BSEL_MAX = 8'(ACT_WIDTH - 1);

    typedef enum logic [2:0] {
        S_DRST,
        S_IDLE,
        S_FILL,
        S_HDR,
        S_LOAD,
        S_MULT
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [7:0]            plane_q, plane_d;
    logic [7:0]            bsel_q, bsel_d;
    logic [VW-1:0]         vec_q, vec_d;
    logic                  stop_q, stop_d;
    logic [MAX_IN_LEN-1:0] tx_word_q, tx_word_d;
    logic                  dut_rst_n_q, dut_rst_n_d;
    logic                  w_ready_q, w_ready_d;
    logic                  a_ready_q, a_ready_d;
    logic                  frame_start_q, frame_start_d;
    logic                  frame_valid_q, frame_valid_d;
    logic                  busy_q, busy_d;
`ifdef TERNARY_TX_WEIGHT_REUSE_EN
    logic                  buf_valid_q, buf_valid_d;
`endif

    logic [MAX_IN_LEN-1:0] wbuf_q [NW];
    logic                  wbuf_we;
    logic                  w_hs, a_hs, stop_now, go_start, go_reuse;
    logic [ACT_WIDTH-1:0]  act;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        plane_d       = plane_q;
        bsel_d        = bsel_q;
        vec_d         = vec_q;
        frame_valid_d = frame_valid_q;
        wbuf_we       = 1'b0;
        act           = '0;
        w_hs          = w_valid & w_ready_q;
        a_hs          = a_valid & a_ready_q;
        stop_now      = stop_q | (stop & busy_q);
`ifdef TERNARY_TX_WEIGHT_REUSE_EN
        buf_valid_d   = buf_valid_q;
        go_start      = start | start_reuse;
        go_reuse      = !start && start_reuse && buf_valid_q;
`else
        go_start      = start;
        go_reuse      = 1'b0;
`endif

        case (state_q)
            S_DRST: begin
                if (cnt_q == CW'(1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_IDLE: begin
                if (go_start) begin
                    bsel_d  = (cfg_bit_select > BSEL_MAX) ? BSEL_MAX : cfg_bit_select;
                    cnt_d   = '0;
                    state_d = go_reuse ? S_HDR : S_FILL;
                end
            end
            S_FILL: begin
                if (w_hs) begin
                    wbuf_we = 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        state_d = S_HDR;
`ifdef TERNARY_TX_WEIGHT_REUSE_EN
                        buf_valid_d = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_HDR: begin
                state_d = S_LOAD;
                cnt_d   = '0;
            end
            S_LOAD: begin
                if (cnt_q == LAST_IDX) begin
                    if (stop_now) begin
                        state_d = S_DRST;
                        cnt_d   = '0;
                    end else begin
                        state_d       = S_MULT;
                        plane_d       = '0;
                        vec_d         = a_hs ? a_data : '0;
                        frame_valid_d = a_hs;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_MULT: begin
                // Frame boundary: either a fresh vector or a zero bubble keeps the core's plane counter aligned.
                if (plane_q == bsel_q) begin
                    if (stop_now) begin
                        state_d = S_DRST;
                        cnt_d   = '0;
                    end else begin
                        plane_d       = '0;
                        vec_d         = a_hs ? a_data : '0;
                        frame_valid_d = a_hs;
                    end
                end else begin
                    plane_d = plane_q + 8'd1;
                end
            end
            default: begin
                state_d = S_DRST;
                cnt_d   = '0;
            end
        endcase

        stop_d = (state_d == S_DRST || state_d == S_IDLE) ? 1'b0 : stop_now;
        if (state_d != S_MULT) frame_valid_d = 1'b0;

        tx_word_d = '0;
        case (state_d)
            S_HDR:  tx_word_d = MAX_IN_LEN'({bsel_d, 4'h1});
            S_LOAD: tx_word_d = wbuf_q[cnt_d];
            S_MULT: begin
                for (int i = 0; i < MAX_IN_LEN; i++) begin
                    act          = vec_d[i*ACT_WIDTH +: ACT_WIDTH];
                    tx_word_d[i] = act[plane_d[PW-1:0]];
                end
            end
            default: tx_word_d = '0;
        endcase

        dut_rst_n_d   = (state_d != S_DRST);
        busy_d        = (state_d != S_IDLE);
        w_ready_d     = (state_d == S_FILL);
        a_ready_d     = !stop_d && (((state_d == S_LOAD) && (cnt_d == LAST_IDX)) ||
                                    ((state_d == S_MULT) && (plane_d == bsel_d)));
        frame_start_d = (state_d == S_MULT) && (plane_d == 8'd0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_DRST;
            cnt_q         <= '0;
            plane_q       <= '0;
            bsel_q        <= '0;
            vec_q         <= '0;
            stop_q        <= 1'b0;
            tx_word_q     <= '0;
            dut_rst_n_q   <= 1'b0;
            w_ready_q     <= 1'b0;
            a_ready_q     <= 1'b0;
            frame_start_q <= 1'b0;
            frame_valid_q <= 1'b0;
            busy_q        <= 1'b1;
`ifdef TERNARY_TX_WEIGHT_REUSE_EN
            buf_valid_q   <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            plane_q       <= plane_d;
            bsel_q        <= bsel_d;
            vec_q         <= vec_d;
            stop_q        <= stop_d;
            tx_word_q     <= tx_word_d;
            dut_rst_n_q   <= dut_rst_n_d;
            w_ready_q     <= w_ready_d;
            a_ready_q     <= a_ready_d;
            frame_start_q <= frame_start_d;
            frame_valid_q <= frame_valid_d;
            busy_q        <= busy_d;
`ifdef TERNARY_TX_WEIGHT_REUSE_EN
            buf_valid_q   <= buf_valid_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (wbuf_we) wbuf_q[cnt_q] <= w_data;
    end

    assign tx_word     = tx_word_q;
    assign dut_rst_n   = dut_rst_n_q;
    assign w_ready     = w_ready_q;
    assign a_ready     = a_ready_q;
    assign frame_start = frame_start_q;
    assign frame_valid = frame_valid_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_ternary_stream_tx.sv
// Bench for ternary_stream_tx: directed sessions with random weights/vectors checked against a session-level model.
module tb_ternary_stream_tx;

    localparam int NW = 24;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
`ifdef TERNARY_TX_WEIGHT_REUSE_EN
    logic        start_reuse = 1'b0;
`endif
    logic [7:0]  cfg_bit_select = 8'd0;
    logic [11:0] w_data = 12'd0;
    logic        w_valid = 1'b0;
    logic [95:0] a_data = '0;
    logic        a_valid = 1'b0;
    logic        w_ready, a_ready, dut_rst_n, frame_start, frame_valid, busy;
    logic [11:0] tx_word;

    ternary_stream_tx dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .stop           (stop),
`ifdef TERNARY_TX_WEIGHT_REUSE_EN
        .start_reuse    (start_reuse),
`endif
        .cfg_bit_select (cfg_bit_select),
        .w_data         (w_data),
        .w_valid        (w_valid),
        .w_ready        (w_ready),
        .a_data         (a_data),
        .a_valid        (a_valid),
        .a_ready        (a_ready),
        .tx_word        (tx_word),
        .dut_rst_n      (dut_rst_n),
        .frame_start    (frame_start),
        .frame_valid    (frame_valid),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [11:0] wt [NW];
    bit          buf_ok = 1'b0;

    // Expected bus word for bit-plane p: bit i is bit p of activation i.
    function automatic logic [11:0] plane_word(input logic [95:0] v, input int p);
        logic [11:0] r;
        int          a;
        r = '0;
        for (int i = 0; i < 12; i++) begin
            a    = int'(v[i*8 +: 8]);
            r[i] = ((a >> p) % 2) == 1;
        end
        return r;
    endfunction

    function automatic logic [95:0] rand_vec();
        return {$urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_cmp++;
        assert (obs === req) else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, req);
        end
    endtask

    task automatic cyc_chk(input string tag, input logic [11:0] e_tx, input bit e_rst, input bit e_busy,
                           input bit e_wr, input bit e_ar, input bit e_fs, input bit e_fv);
        chk({tag, ".tx_word"},     32'(tx_word),     32'(e_tx));
        chk({tag, ".dut_rst_n"},   32'(dut_rst_n),   32'(e_rst));
        chk({tag, ".busy"},        32'(busy),        32'(e_busy));
        chk({tag, ".w_ready"},     32'(w_ready),     32'(e_wr));
        chk({tag, ".a_ready"},     32'(a_ready),     32'(e_ar));
        chk({tag, ".frame_start"}, 32'(frame_start), 32'(e_fs));
        chk({tag, ".frame_valid"}, 32'(frame_valid), 32'(e_fv));
    endtask

    task automatic drst_idle(input string tag);
        cyc_chk({tag, ".drst0"}, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        cyc_chk({tag, ".drst1"}, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        cyc_chk({tag, ".idle"},  12'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        w_valid = 1'b0;
        a_valid = 1'b0;
`ifdef TERNARY_TX_WEIGHT_REUSE_EN
        start_reuse = 1'b0;
`endif
        repeat (2) @(negedge clk);
        cyc_chk("reset", 12'h000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        cyc_chk("release.drst", 12'h000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        cyc_chk("release.idle", 12'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        buf_ok = 1'b0;
    endtask

    // One session from IDLE back to IDLE; the last frame carries the stop at plane stop_pl.
    task automatic session(input string tag, input int cfg, input int nfr, input int stop_pl, input bit fixed,
                           input bit early, input bit reuse, input bit with_stop, input int abort_k);
        int          bsel, nf, acc, guard;
        logic [11:0] hdr;
        bit          fill_path, stop_pend, take, ar_exp;
        logic [95:0] cur;
        bit          cur_v;

        bsel      = (cfg > 7) ? 7 : cfg;
        hdr       = 12'((bsel << 4) + 1);
        fill_path = !(reuse && buf_ok);
        stop_pend = 1'b0;
        nf        = nfr;
        if (fill_path)
            for (int k = 0; k < NW; k++) wt[k] = fixed ? 12'(k + 1) : 12'($urandom);

        cfg_bit_select = 8'(cfg);
`ifdef TERNARY_TX_WEIGHT_REUSE_EN
        start       = !reuse;
        start_reuse = reuse;
`else
        start       = 1'b1;
`endif
        stop = with_stop;
        @(negedge clk);
        start = 1'b0;
`ifdef TERNARY_TX_WEIGHT_REUSE_EN
        start_reuse = 1'b0;
`endif
        stop = 1'b0;

        if (fill_path) begin
            acc   = 0;
            guard = 0;
            while (acc < NW && guard < 400) begin
                cyc_chk({tag, ".fill"}, 12'h000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
                stop = early && (guard == 0);
                if (stop) stop_pend = 1'b1;
                w_valid = fixed ? (guard % 2 == 0) : ($urandom_range(0, 3) != 0);
                w_data  = wt[acc];
                @(negedge clk);
                if (w_valid) acc++;
                guard++;
            end
            w_valid = 1'b0;
            stop    = 1'b0;
            buf_ok  = 1'b1;
        end

        cyc_chk({tag, ".hdr"}, hdr, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);

        for (int k = 0; k < NW; k++) begin
            cyc_chk({tag, ".load"}, wt[k], 1'b1, 1'b1, 1'b0, (k == NW - 1) && !stop_pend, 1'b0, 1'b0);
            if (k == abort_k) return;
            if (k == NW - 1 && !stop_pend) begin
                a_valid = 1'b1;
                a_data  = fixed ? {12{8'h05}} : rand_vec();
            end
            @(negedge clk);
        end
        take  = a_valid;
        cur   = take ? a_data : '0;
        cur_v = take;
        if (stop_pend) nf = 0;

        for (int f = 0; f < nf; f++) begin
            ar_exp = 1'b0;
            for (int p = 0; p <= bsel; p++) begin
                ar_exp = (p == bsel) && !stop_pend;
                cyc_chk({tag, ".mult"}, plane_word(cur, p), 1'b1, 1'b1, 1'b0, ar_exp, p == 0, cur_v);
                if (p == 0) begin
                    if (f == nf - 1) a_valid = 1'b0;
                    else if (fixed && f == 0) a_valid = 1'b0;
                    else if (fixed && f == 1) begin
                        a_valid = 1'b1;
                        a_data  = rand_vec();
                    end else begin
                        a_valid = ($urandom_range(0, 3) != 0);
                        a_data  = rand_vec();
                    end
                end
                start = (f == 0) && (p == 0);
                stop  = (f == nf - 1) && (p == stop_pl);
                if (stop) stop_pend = 1'b1;
                @(negedge clk);
            end
            take  = a_valid && ar_exp;
            cur   = take ? a_data : '0;
            cur_v = take;
            start = 1'b0;
            stop  = 1'b0;
        end
        a_valid = 1'b0;
        drst_idle(tag);
    endtask

    initial begin
        int cfg_r, b_r;
        do_reset();
        session("s1_bsel3",  3,  5, 1, 1'b1, 1'b0, 1'b0, 1'b0, -1);
        session("s2_clamp",  32, 3, 4, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        session("s3_bsel0",  0,  6, 0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        session("s4_early",  1,  3, 0, 1'b0, 1'b1, 1'b0, 1'b0, -1);
        for (int r = 0; r < 3; r++) begin
            cfg_r = $urandom_range(0, 12);
            b_r   = (cfg_r > 7) ? 7 : cfg_r;
            session("rnd", cfg_r, 3 + $urandom_range(0, 2), $urandom_range(0, b_r), 1'b0, 1'b0, 1'b0, 1'b0, -1);
        end
`ifdef TERNARY_TX_WEIGHT_REUSE_EN
        session("reuse",     2,  3, 1, 1'b0, 1'b0, 1'b1, 1'b0, -1);
`endif
        session("abort",     2,  3, 0, 1'b0, 1'b0, 1'b0, 1'b0, 5);
        do_reset();
        session("post_rst",  4,  2, 2, 1'b0, 1'b0, 1'b1, 1'b0, -1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
